// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types.
//   mem_state_t : data-memory handshake states (IDLE, WAIT, FAULT)
//   ex_mem_t    : EX/MEM pipeline register contents
//   mem_wb_t    : MEM/WB pipeline register contents
package mips_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FAULT
  } mem_state_t;

  typedef struct packed {
    logic [31:0]      alu_result;
    logic [31:0]      write_data;
    logic [REG_W-1:0] reg_dest;
    logic             zero;
    logic [31:0]      branch_addr;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0]      alu_result;
    logic [31:0]      read_data;
    logic [REG_W-1:0] reg_dest;
    logic             reg_write;
    logic             mem_to_reg;
  } mem_wb_t;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory request/acknowledge handshake with timeout.
//   clk, rst_n : clock, asynchronous active-low reset
//   memop      : EX/MEM holds a load or store
//   ack        : memory access complete this cycle
//   req        : memory request (combinational)
//   stall      : freeze upstream stages and EX/MEM
//   fault      : sticky timeout indication, cleared only by reset
module mem_access_fsm
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic memop,
  input  logic ack,
  output logic req,
  output logic stall,
  output logic fault
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The IDLE request cycle counts as the first unacknowledged cycle; the
  // WAIT counter then covers the remaining TIMEOUT-1 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    stall   = 1'b0;
    fault   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (memop) begin
          req = 1'b1;
          if (!ack) begin
            stall   = 1'b1;
            cnt_d   = '0;
            state_d = (TIMEOUT <= 1) ? ST_FAULT : ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (memop) begin
          req = 1'b1;
          if (ack) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            stall = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(TIMEOUT - 1)) begin
              state_d = ST_FAULT;
            end
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_FAULT: begin
        stall = 1'b1;
        fault = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM and MEM/WB pipeline registers, data-memory
// handshake, branch resolution and forwarding/writeback outputs.
//   ex_*            : execute-stage results and control bits
//   dmem_*          : data-memory request/ack interface
//   EXtoMEM_*       : EX/MEM values for forwarding
//   WB_*            : MEM/WB writeback value, destination, enable
//   PCSrc/Branch_target : branch taken and target from EX/MEM
//   mem_stall/mem_fault : pipeline freeze and sticky timeout
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      ex_ALUresult,
  input  logic [31:0]      ex_WriteData,
  input  logic [REG_W-1:0] ex_RegDest,
  input  logic             ex_zero,
  input  logic [31:0]      ex_BranchAddr,
  input  logic             ex_RegWrite,
  input  logic             ex_MemtoReg,
  input  logic             ex_MemRead,
  input  logic             ex_MemWrite,
  input  logic             ex_Branch,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  input  logic             dmem_ack,
  input  logic [31:0]      dmem_rdata,
  output logic [31:0]      EXtoMEM_ALUresult,
  output logic [REG_W-1:0] EXtoMEM_RegDest,
  output logic             EXtoMEM_RegWrite,
  output logic [31:0]      WB_ALUresult,
  output logic [REG_W-1:0] WB_RegDest,
  output logic             WB_RegWrite,
  output logic             PCSrc,
  output logic [31:0]      Branch_target,
  output logic             mem_stall,
  output logic             mem_fault
);

  ex_mem_t ex_mem_q, ex_mem_d;
  mem_wb_t mem_wb_q, mem_wb_d;
  logic    memop;

  assign memop = ex_mem_q.mem_read | ex_mem_q.mem_write;

  mem_access_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clk   (clk),
    .rst_n (rst_n),
    .memop (memop),
    .ack   (dmem_ack),
    .req   (dmem_req),
    .stall (mem_stall),
    .fault (mem_fault)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  // Stall takes priority over the branch squash.
  always_comb begin
    ex_mem_d = ex_mem_q;
    if (!mem_stall) begin
      if (PCSrc) begin
        ex_mem_d = '0;
      end else begin
        ex_mem_d.alu_result  = ex_ALUresult;
        ex_mem_d.write_data  = ex_WriteData;
        ex_mem_d.reg_dest    = ex_RegDest;
        ex_mem_d.zero        = ex_zero;
        ex_mem_d.branch_addr = ex_BranchAddr;
        ex_mem_d.reg_write   = ex_RegWrite;
        ex_mem_d.mem_to_reg  = ex_MemtoReg;
        ex_mem_d.mem_read    = ex_MemRead;
        ex_mem_d.mem_write   = ex_MemWrite;
        ex_mem_d.branch      = ex_Branch;
      end
    end
  end

  always_comb begin
    mem_wb_d = '0;
    if (!mem_stall) begin
      mem_wb_d.alu_result = ex_mem_q.alu_result;
      mem_wb_d.read_data  = ex_mem_q.mem_read ? dmem_rdata : '0;
      mem_wb_d.reg_dest   = ex_mem_q.reg_dest;
      mem_wb_d.reg_write  = ex_mem_q.reg_write;
      mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
    end
  end

  assign dmem_we           = ex_mem_q.mem_write;
  assign dmem_addr         = ex_mem_q.alu_result;
  assign dmem_wdata        = ex_mem_q.write_data;
  assign EXtoMEM_ALUresult = ex_mem_q.alu_result;
  assign EXtoMEM_RegDest   = ex_mem_q.reg_dest;
  assign EXtoMEM_RegWrite  = ex_mem_q.reg_write;
  assign PCSrc             = ex_mem_q.branch & ex_mem_q.zero;
  assign Branch_target     = ex_mem_q.branch_addr;
  assign WB_ALUresult      = mem_wb_q.mem_to_reg ? mem_wb_q.read_data : mem_wb_q.alu_result;
  assign WB_RegDest        = mem_wb_q.reg_dest;
  assign WB_RegWrite       = mem_wb_q.reg_write;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 5-stage MIPS pipeline. Holds the EX/MEM and MEM/WB pipeline registers and runs the data-memory request/acknowledge handshake. Resolves branches. Produces the forwarding operands `EXtoMEM_ALUresult` and `WB_ALUresult` that the execute stage's forwarding muxes select with `ForwardA`/`ForwardB`.

## Interface

**Parameters**
- `TIMEOUT`, 16: maximum wait cycles for `dmem_ack` before a fault is declared.

**Ports**
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ex_ALUresult` in 32: ALU result from execute.
- `ex_WriteData` in 32: forwarded Rt value, used as store data.
- `ex_RegDest` in 5: destination register.
- `ex_zero` in 1: ALU zero flag.
- `ex_BranchAddr` in 32: computed branch target.
- `ex_RegWrite` in 1: control bit from execute.
- `ex_MemtoReg` in 1: control bit from execute.
- `ex_MemRead` in 1: control bit from execute.
- `ex_MemWrite` in 1: control bit from execute.
- `ex_Branch` in 1: control bit from execute.
- `dmem_req` out 1: data-memory request.
- `dmem_we` out 1: write enable (1 = store).
- `dmem_addr` out 32: word address, equal to EX/MEM ALU result.
- `dmem_wdata` out 32: store data.
- `dmem_ack` in 1: access complete; read data valid in the same cycle.
- `dmem_rdata` in 32: load data.
- `EXtoMEM_ALUresult` out 32: EX/MEM ALU register (forwarding).
- `EXtoMEM_RegDest` out 5: EX/MEM destination (forwarding).
- `EXtoMEM_RegWrite` out 1: EX/MEM RegWrite (forwarding).
- `WB_ALUresult` out 32: selected writeback value; read data if MemtoReg, else ALU result.
- `WB_RegDest` out 5: MEM/WB destination register.
- `WB_RegWrite` out 1: MEM/WB write enable.
- `PCSrc` out 1: branch taken, `Branch & zero` of EX/MEM.
- `Branch_target` out 32: EX/MEM branch address.
- `mem_stall` out 1: freeze IF/ID/EX and the EX/MEM register.
- `mem_fault` out 1: sticky data-memory timeout.

## Operation

- A memory op is an EX/MEM entry with `MemRead | MemWrite`.
- **FSM states:** IDLE, WAIT, FAULT.
- **IDLE**
  - If a memory op is present: `dmem_req = 1` combinationally.
  - If `dmem_ack` arrives in the same cycle, the op completes.
  - Otherwise the FSM moves to WAIT and clears the wait counter.
- **WAIT**
  - `dmem_req` stays high.
  - Each cycle without ack increments the counter.
  - Ack returns the FSM to IDLE.
  - Counter reaching `TIMEOUT-1` without ack moves the FSM to FAULT.
- **FAULT**
  - `dmem_req = 0`, `mem_fault = 1`, `mem_stall = 1`.
  - Exit only by reset.
- `mem_stall = (memop & ~dmem_ack & state != FAULT) | (state == FAULT)`.
- **While stalled**
  - EX/MEM holds its contents.
  - MEM/WB loads a bubble: RegWrite = 0, other fields don't-care but zeroed.
  - `dmem_addr`, `dmem_we` and `dmem_wdata` stay stable while `dmem_req` is high.
- **On completion or non-memory op:** MEM/WB captures ALUresult, `dmem_rdata` (loads only), RegDest, RegWrite and MemtoReg.
- **When `PCSrc = 1`**
  - EX/MEM loads a bubble: all control bits 0; wrong-path instruction squashed.
  - The upstream squash of IF/ID and ID/EX is owned by the hazard unit.
- **Stall vs. PCSrc:** a branch entry is never a memory op, so `mem_stall` and `PCSrc` are never both 1. If both appear, stall wins.
- Stray `dmem_ack` in IDLE with no memory op is ignored.
- **Store:** `dmem_we = MemWrite`. MEM/WB RegWrite follows the decoded control, which is 0 for stores.

## Timing

- **Reset (async assert):** all outputs and registers 0, FSM in IDLE, counter 0, `mem_fault = 0`. Registered outputs are 0 until the first clock after deassertion.
- Reset mid-access drops `dmem_req` immediately; the pending access is abandoned.
- **Latency:** one cycle EX/MEM→MEM/WB for non-memory ops and zero-wait memory ops (ack in the request cycle).
- An access whose ack arrives N cycles after the request stalls exactly N cycles.
- **Fault:** declared after `TIMEOUT` consecutive unacknowledged request cycles. `mem_fault` rises in the following cycle.
- `PCSrc` and `Branch_target` are combinational from EX/MEM; valid in the cycle the branch sits in MEM.
- `WB_ALUresult` is combinational from MEM/WB; it is a mux, with no added cycle.

## Structure

- **Shared package `mips_pkg`:**
  - `mem_state_t` enum (IDLE, WAIT, FAULT).
  - `ex_mem_t` and `mem_wb_t` struct typedefs.
  - Register-index width constant (5).
- **Sub-module `mem_access_fsm`:**
  - Inputs: memop, ack.
  - Outputs: req, stall, fault.
  - Contains the state and the timeout counter.
- The pipeline registers and the writeback mux live in the top.

## Test plan

- **ALU op, no memory:** `ex_ALUresult = 0x0000_0010`, RegWrite = 1, rd = 8 → next cycle `EXtoMEM_ALUresult = 0x10`; one cycle later `WB_ALUresult = 0x10`, `WB_RegDest = 8`; `mem_stall` never set.
- **Zero-wait load:** address 0x40, ack in the same cycle with rdata 0xDEAD_BEEF → no stall; `WB_ALUresult = 0xDEADBEEF`.
- **Store, ack after 3 cycles:** address 0x80, wdata 0x1234_5678 → `mem_stall` high for exactly 3 cycles; addr/wdata/we stable; MEM/WB RegWrite = 0 throughout.
- **Taken branch:** Branch = 1, zero = 1, target 0x0040_0020 → `PCSrc = 1` with `Branch_target = 0x00400020`; the following EX/MEM entry has RegWrite = 0.
- **Timeout:** `TIMEOUT = 4`, load with no ack → FAULT after 4 request cycles; then `mem_fault = 1`, `dmem_req = 0`, `mem_stall = 1` held. Reset clears all of these.
- **Reset mid-wait:** `rst_n` low during WAIT → `dmem_req` 0 asynchronously and all outputs 0.
